// File: rtl/lock_pkg.sv
// Shared encodings for the lock chamber: sequencer states and gate selection.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } lvl_state_t;

    localparam logic GATE_DOWN = 1'b0;
    localparam logic GATE_UP   = 1'b1;

endpackage

// File: rtl/sat_level_counter.sv
// Chamber level register with rate-stepped up/down moves clamped to [LOW_LVL, HIGH_LVL].
module sat_level_counter #(
    parameter int LVL_W      = 8,
    parameter int LOW_LVL    = 0,
    parameter int HIGH_LVL   = 20,
    parameter int FILL_RATE  = 1,
    parameter int DRAIN_RATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             step,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W:0]   LOW_W   = (LVL_W+1)'(LOW_LVL);
    localparam logic [LVL_W:0]   HIGH_W  = (LVL_W+1)'(HIGH_LVL);
    localparam logic [LVL_W:0]   UP_W    = (LVL_W+1)'(FILL_RATE);
    localparam logic [LVL_W:0]   DN_W    = (LVL_W+1)'(DRAIN_RATE);
    localparam logic [LVL_W-1:0] LOW_L   = LVL_W'(LOW_LVL);
    localparam logic [LVL_W-1:0] HIGH_L  = LVL_W'(HIGH_LVL);
    localparam logic [LVL_W-1:0] DN_L    = LVL_W'(DRAIN_RATE);

    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic [LVL_W:0]   sum_up;
    logic [LVL_W-1:0] up_val;
    logic [LVL_W-1:0] dn_val;

    // Extra top bit keeps the sum from wrapping before the clamp.
    assign sum_up = {1'b0, level_reg} + UP_W;
    assign up_val = (sum_up >= HIGH_W) ? HIGH_L : sum_up[LVL_W-1:0];
    assign dn_val = ({1'b0, level_reg} < (LOW_W + DN_W)) ? LOW_L : (level_reg - DN_L);

    always_comb begin
        level_next = level_reg;
        if (step && inc) begin
            level_next = up_val;
        end else if (step && dec) begin
            level_next = dn_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_reg <= LOW_L;
        end else begin
            level_reg <= level_next;
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/water_level_ctrl.sv
// Lock-chamber fill/drain sequencer: FSM, valve decode, done pulse and diffOk for the gate block.
module water_level_ctrl
    import lock_pkg::*;
#(
    parameter int LVL_W      = 8,
    parameter int LOW_LVL    = 0,
    parameter int HIGH_LVL   = 20,
    parameter int FILL_RATE  = 1,
    parameter int DRAIN_RATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             reqFill,
    input  logic             reqDrain,
    input  logic             gatesClosed,
    input  logic             whatGate,
    output logic             fillValve,
    output logic             drainValve,
    output logic [LVL_W-1:0] level,
    output logic             busy,
    output logic             done,
    output logic             diffOk
);

    localparam logic [LVL_W:0]   LOW_W  = (LVL_W+1)'(LOW_LVL);
    localparam logic [LVL_W:0]   HIGH_W = (LVL_W+1)'(HIGH_LVL);
    localparam logic [LVL_W:0]   UP_W   = (LVL_W+1)'(FILL_RATE);
    localparam logic [LVL_W:0]   DN_W   = (LVL_W+1)'(DRAIN_RATE);
    localparam logic [LVL_W-1:0] LOW_L  = LVL_W'(LOW_LVL);
    localparam logic [LVL_W-1:0] HIGH_L = LVL_W'(HIGH_LVL);

    lvl_state_t state_reg;
    lvl_state_t state_next;
    logic       done_reg;
    logic       done_next;
    logic       fill_hit;
    logic       drain_hit;
    logic       move_up;
    logic       move_dn;

    // The counter clamps, so a tick reaches the target exactly when the unclamped move would meet or pass it.
    assign fill_hit  = ({1'b0, level} + UP_W) >= HIGH_W;
    assign drain_hit = {1'b0, level} <= (LOW_W + DN_W);

    // An open gate blocks movement in the same cycle it aborts the FSM.
    assign move_up = (state_reg == FILL)  && gatesClosed;
    assign move_dn = (state_reg == DRAIN) && gatesClosed;

    sat_level_counter #(
        .LVL_W      (LVL_W),
        .LOW_LVL    (LOW_LVL),
        .HIGH_LVL   (HIGH_LVL),
        .FILL_RATE  (FILL_RATE),
        .DRAIN_RATE (DRAIN_RATE)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (move_up),
        .dec   (move_dn),
        .step  (tick),
        .level (level)
    );

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gatesClosed && reqFill && !reqDrain && (level < HIGH_L)) begin
                    state_next = FILL;
                end else if (gatesClosed && reqDrain && !reqFill && (level > LOW_L)) begin
                    state_next = DRAIN;
                end
            end
            FILL: begin
                if (!gatesClosed) begin
                    state_next = IDLE;
                end else if (tick && fill_hit) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            DRAIN: begin
                if (!gatesClosed) begin
                    state_next = IDLE;
                end else if (tick && drain_hit) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    assign fillValve  = (state_reg == FILL);
    assign drainValve = (state_reg == DRAIN);
    assign busy       = fillValve || drainValve;
    assign done       = done_reg;
    assign diffOk     = (state_reg == IDLE) &&
                        ((whatGate == GATE_UP) ? (level == HIGH_L) : (level == LOW_L));

endmodule

// File: tb/tb_water_level_ctrl.sv
// Directed and randomized bench for water_level_ctrl against a cycle-level behavioural model.
module tb_water_level_ctrl;

    localparam int LVL_W = 8;
    localparam int LOW   = 0;
    localparam int HIGH  = 20;
    localparam int FRATE = 1;
    localparam int DRATE = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick = 1'b0;
    logic             reqFill = 1'b0;
    logic             reqDrain = 1'b0;
    logic             gatesClosed = 1'b0;
    logic             whatGate = 1'b0;
    logic             fillValve;
    logic             drainValve;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             done;
    logic             diffOk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 = at rest, 1 = raising, 2 = lowering.
    int m_mode = 0;
    int m_lvl  = LOW;
    int m_done = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    water_level_ctrl #(
        .LVL_W      (LVL_W),
        .LOW_LVL    (LOW),
        .HIGH_LVL   (HIGH),
        .FILL_RATE  (FRATE),
        .DRAIN_RATE (DRATE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .reqFill     (reqFill),
        .reqDrain    (reqDrain),
        .gatesClosed (gatesClosed),
        .whatGate    (whatGate),
        .fillValve   (fillValve),
        .drainValve  (drainValve),
        .level       (level),
        .busy        (busy),
        .done        (done),
        .diffOk      (diffOk)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_diff(input logic wg);
        if (m_mode != 0) return 0;
        return wg ? int'(m_lvl == HIGH) : int'(m_lvl == LOW);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".fillValve"},  32'(fillValve),  32'(m_mode == 1));
        check({tag, ".drainValve"}, 32'(drainValve), 32'(m_mode == 2));
        check({tag, ".busy"},       32'(busy),       32'(m_mode != 0));
        check({tag, ".done"},       32'(done),       32'(m_done));
        check({tag, ".level"},      32'(level),      32'(m_lvl));
        check({tag, ".diffOk"},     32'(diffOk),     32'(exp_diff(whatGate)));
    endtask

    // Apply inputs for one cycle, advance the model across the edge, then compare.
    task automatic step(input string tag, input logic rf, input logic rd,
                        input logic gc, input logic tk, input logic wg);
        reqFill = rf; reqDrain = rd; gatesClosed = gc; tick = tk; whatGate = wg;
        @(posedge clk);
        m_done = 0;
        if (m_mode == 0) begin
            if (gc && rf && !rd && m_lvl < HIGH) m_mode = 1;
            else if (gc && rd && !rf && m_lvl > LOW) m_mode = 2;
        end else if (!gc) begin
            m_mode = 0;
        end else if (tk) begin
            if (m_mode == 1) m_lvl = (m_lvl + FRATE > HIGH) ? HIGH : m_lvl + FRATE;
            else             m_lvl = (m_lvl - DRATE < LOW) ? LOW : m_lvl - DRATE;
            if ((m_mode == 1 && m_lvl == HIGH) || (m_mode == 2 && m_lvl == LOW)) begin
                m_mode = 0;
                m_done = 1;
            end
        end
        #1;
        if (done === 1'b1) done_seen++;
        check_all(tag);
    endtask

    initial begin
        // 1: reset
        #12;
        reset = 1'b1;
        #3;
        check("rst.level", 32'(level), 32'(LOW));
        check("rst.valves", 32'({fillValve, drainValve, busy, done}), 32'(0));
        whatGate = 1'b0; #1;
        check("rst.diffOk_down", 32'(diffOk), 32'(1));
        whatGate = 1'b1; #1;
        check("rst.diffOk_up", 32'(diffOk), 32'(0));
        @(posedge clk); #1;

        // 2: full fill
        step("fill.req", 1, 0, 1, 0, 1);
        check("fill.valve_on", 32'(fillValve), 32'(1));
        done_seen = 0;
        for (int i = 0; i < HIGH; i++) step("fill.tick", 0, 0, 1, 1, 1);
        step("fill.after", 0, 0, 1, 0, 1);
        check("fill.level_top", 32'(level), 32'(HIGH));
        check("fill.done_once", 32'(done_seen), 32'(1));
        check("fill.diffOk_up", 32'(diffOk), 32'(1));
        step("fill.at_target", 1, 0, 1, 1, 1);
        check("fill.no_redo", 32'(fillValve), 32'(0));

        // drain back to LOW to set up test 3/4
        step("drain.req", 0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) step("drain.tick", 0, 0, 1, 1, 0);

        // 3: request with a gate open
        step("open.req", 1, 0, 0, 1, 0);
        check("open.no_fill", 32'(fillValve), 32'(0));

        // 4: fill to 7, abort with a simultaneous tick
        step("abort.req", 1, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step("abort.tick", 0, 0, 1, 1, 0);
        step("abort.edge", 0, 0, 0, 1, 0);
        check("abort.level7", 32'(level), 32'(7));
        whatGate = 1'b1; #1;
        check("abort.diffOk_up", 32'(diffOk), 32'(0));

        // 5: raise to 10, both requests, then drain by 3
        step("l10.req", 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("l10.tick", 0, 0, 1, 1, 0);
        step("l10.abort", 0, 0, 0, 0, 0);
        check("l10.level", 32'(level), 32'(10));
        step("both.req", 1, 1, 1, 1, 0);
        check("both.no_valve", 32'({fillValve, drainValve}), 32'(0));
        step("dr3.req", 0, 1, 1, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) step("dr3.tick", 0, 0, 1, 1, 0);
        check("dr3.level0", 32'(level), 32'(LOW));
        check("dr3.done_once", 32'(done_seen), 32'(1));
        step("dr3.idle_tick", 0, 0, 1, 1, 0);

        // 6: async reset mid-fill at level 12
        step("mid.req", 1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step("mid.tick", 0, 0, 1, 1, 0);
        check("mid.level12", 32'(level), 32'(12));
        #2 reset = 1'b0;
        #1;
        check("mid.async_valves", 32'({fillValve, drainValve, busy}), 32'(0));
        check("mid.async_level", 32'(level), 32'(LOW));
        m_mode = 0; m_lvl = LOW; m_done = 0;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        step("mid.released", 0, 0, 1, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 11) != 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
